// File: rtl/approx_add_pkg.sv
// Shared types and helpers for the approximate-adder scheduler.
// Provides the round-robin pick used by the arbiter.
package approx_add_pkg;

    localparam int ADD_W   = 8;
    localparam int SUM_W   = 9;
    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    typedef logic [PTR_W-1:0] rr_ptr;

    typedef struct packed {
        logic  found;
        rr_ptr idx;
    } rr_pick_t;

    // First valid index at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input rr_ptr              ptr,
        input int                 n
    );
        rr_pick_t r;
        int j;
        r = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = (int'(ptr) + k) % n;
                if (!r.found && valid[j[PTR_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[PTR_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_add_core.sv
// Approximate 8-bit adder library core (error-injecting variant).
// Adds 3 to the exact sum whenever A is 0xFF.
module approx_add_core (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [8:0] O
);

    always_comb begin
        O = {1'b0, A} + {1'b0, B};
        if (A == 8'hFF) begin
            O = O + 9'd3;
        end
    end

endmodule

// File: rtl/approx_add_sched_rr_arbiter.sv
// Round-robin arbiter: combinational pick plus the priority pointer.
// The pointer moves past the winner on every issued grant.
module rr_arbiter
    import approx_add_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] valid,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_ok
);

    logic [ID_W-1:0] ptr;
    rr_pick_t        pick;
    logic            pick_unused;

    always_comb begin
        pick = rr_pick(MAX_REQ'(valid), rr_ptr'(ptr), N_REQ);
    end

    assign pick_unused = ^pick;
    assign gnt_idx     = pick.idx[ID_W-1:0];
    assign gnt_ok      = en & pick.found;

    always_comb begin
        grant = '0;
        if (gnt_ok) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_ok) begin
            ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/approx_add_sched.sv
// Shares one approximate adder among N_REQ requesters with a
// registered response stage and an exact-sum error monitor.
module approx_add_sched
    import approx_add_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ERR_CNT_W = 16,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*ADD_W-1:0] req_a,
    input  logic [N_REQ*ADD_W-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [SUM_W-1:0]       rsp_sum,
    output logic                   rsp_err,
    input  logic                   mon_clr,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]       err_max
);

    logic             stage_free;
    logic             gnt_ok;
    logic [ID_W-1:0]  gnt_idx;
    logic [ADD_W-1:0] a_sel;
    logic [ADD_W-1:0] b_sel;
    logic [SUM_W-1:0] core_o;
    logic [SUM_W-1:0] exact;
    logic [SUM_W-1:0] err_mag;
    logic             mismatch;

    // Reset also masks grants so nothing is accepted while held.
    assign stage_free = (~rsp_valid | rsp_ready) & ~rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (req_valid),
        .en      (stage_free),
        .grant   (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_ok  (gnt_ok)
    );

    assign a_sel = req_a[gnt_idx*ADD_W +: ADD_W];
    assign b_sel = req_b[gnt_idx*ADD_W +: ADD_W];

    approx_add_core u_core (
        .A (a_sel),
        .B (b_sel),
        .O (core_o)
    );

    assign exact    = {1'b0, a_sel} + {1'b0, b_sel};
    assign mismatch = (core_o != exact);
    assign err_mag  = (core_o >= exact) ? core_o - exact : exact - core_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_err   <= 1'b0;
        end else if (gnt_ok) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_sum   <= core_o;
            rsp_err   <= mismatch;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (mon_clr) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (gnt_ok && mismatch) begin
            if (~&err_cnt) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (err_mag > err_max) begin
                err_max <= err_mag;
            end
        end
    end

endmodule

// File: doc/approx_add_sched.md
Name: approx_add_sched

Overview:
- Shares one combinational 8-bit approximate adder core (ports A[7:0], B[7:0], O[8:0]) among N_REQ requesters.
- Uses round-robin arbitration, a registered response stage with backpressure, and an exact-sum shadow monitor.
- The monitor counts approximation errors and tracks the worst-case error seen in operation.
- Sits between the accelerator request fabric and the adder library instance.

Parameters:
- N_REQ, 4, number of requesters (2..8); ID_W = clog2(N_REQ), derived.
- ERR_CNT_W, 16, width of the saturating mismatch counter.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester operand valid
- req_a  in  N_REQ*8  packed operand A, requester i at bits [8i+7:8i]
- req_b  in  N_REQ*8  packed operand B, same packing
- req_ready  out  N_REQ  one-hot grant/accept, at most one bit set
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  downstream accepts the response
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_sum  out  9  core output O for that request
- rsp_err  out  1  core output differed from exact A+B
- mon_clr  in  1  synchronous clear of the monitor registers
- err_cnt  out  ERR_CNT_W  saturating count of mismatching operations
- err_max  out  9  maximum |O - (A+B)| seen so far

Behaviour:
- Reset (async, rst=1):
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_err=0.
  - err_cnt=0, err_max=0, round-robin pointer=0 (requester 0 has highest priority).
- Output stage is free when rsp_valid=0 or (rsp_valid & rsp_ready).
- Grant is combinational in the same cycle:
  - When the output stage is free and any req_valid is set, req_ready[g]=1 for g = first valid index at or after the pointer, wrapping modulo N_REQ.
  - When the output stage is not free, req_ready is all zeros.
- Transfer occurs on req_valid[g] & req_ready[g]. On that clock edge:
  - rsp_valid<=1, rsp_id<=g, rsp_sum<=core O, rsp_err<=(O != A+B).
  - pointer<=(g+1) mod N_REQ.
- Latency: 1 cycle from accepted request to rsp_valid.
- Throughput: 1 result per cycle while rsp_ready=1.
- Pop without refill (rsp_valid & rsp_ready with no transfer): rsp_valid<=0. rsp_id, rsp_sum and rsp_err hold their values.
- With rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable and no grant is issued.
- Core operand mux selects requester g's operands. The exact sum is a 9-bit A+B computed alongside the core.
- Error magnitude e = |O - (A+B)|, computed as a 9-bit unsigned difference.
- Monitor update on each transfer with a mismatch:
  - err_cnt increments and saturates at all-ones.
  - err_max<=max(err_max, e).
- mon_clr=1 zeroes err_cnt and err_max on that edge. It has priority over a same-cycle update; that update is lost.
- Requesters must hold req_a/req_b stable while req_valid=1 and not granted. Dropping req_valid before grant is legal and loses the request.
- Mid-operation reset clears rsp_valid immediately. Any in-flight response is discarded, with no partial output.

Decomposition:
- Package approx_add_pkg:
  - ADD_W=8 and SUM_W=9.
  - rr_ptr typedef and a function rr_pick(valid, ptr) returning the granted index and a found flag.
- Sub-module rr_arbiter: the N_REQ-wide combinational round-robin pick plus the pointer register.
- The adder core is a plain instance inside approx_add_sched. Integration selects which library core is bound.

Test Plan:
- Reset mid-response: with rsp_valid=1, assert rst -> rsp_valid=0 immediately, err_cnt=0, next grant goes to requester 0.
- Exact stub, req0 only, a=0x10, b=0x21, rsp_ready=1 -> req_ready=0001 in cycle 0; cycle 1: rsp_valid=1, rsp_id=0, rsp_sum=0x031, rsp_err=0.
- All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on successive cycles, one rsp per cycle, ids in the same order.
- Backpressure: rsp_ready=0 for 3 cycles with req1 and req2 pending -> rsp_* stable, req_ready=0000. When rsp_ready rises: req1 is granted that cycle, then req2 the next cycle.
- Error-injecting stub (O=A+B+3 when A=0xFF), a=0xFF, b=0x01 -> rsp_sum=0x103, rsp_err=1, err_cnt=1, err_max=3. Repeat 2^16 times -> err_cnt saturates at 0xFFFF.
- mon_clr in the same cycle as a mismatching transfer -> err_cnt=0, err_max=0 afterwards, while the response is still delivered with rsp_err=1.
